// File: rtl/switch_control_pkg.sv
// switch_control_pkg: shared sizes, port indices and FSM state type for the router connection controller
package switch_control_pkg;
  localparam int NPORT = 5;
  localparam int TAM_FLIT = 8;
  localparam int METADEFLIT = TAM_FLIT / 2;
  localparam logic [2:0] EAST = 3'd0;
  localparam logic [2:0] WEST = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;
  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, ROUTE = 2'd2, GRANT = 2'd3} state_t;
endpackage

// File: rtl/switch_control_if.sv
// switch_control_if: bundle between the five input buffers and the connection controller
//   h, data_in, sender : buffer side -> controller (header pending, head flits, forwarding)
//   ack_h, free        : controller -> buffers (grant pulse, output unallocated)
//   mux_in, mux_out    : controller -> crossbar (selected input per output, output per input)
interface switch_control_if;
  import switch_control_pkg::*;
  logic [NPORT-1:0] h;
  logic [NPORT*TAM_FLIT-1:0] data_in;
  logic [NPORT-1:0] sender;
  logic [NPORT-1:0] ack_h;
  logic [NPORT-1:0] free;
  logic [NPORT*3-1:0] mux_in;
  logic [NPORT*3-1:0] mux_out;
  modport master (output h, data_in, sender, input ack_h, free, mux_in, mux_out);
  modport slave (input h, data_in, sender, output ack_h, free, mux_in, mux_out);
endinterface

// File: rtl/switch_control_rr_picker.sv
// rr_picker: combinational 5-way round-robin first-one search starting just after last
//   req   : request vector
//   last  : most recently selected index
//   sel   : first requesting index after last, wrapping
//   valid : some request is pending
module rr_picker
  import switch_control_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [2:0]       last,
  output logic [2:0]       sel,
  output logic             valid
);
  logic [2:0] k;
  always_comb begin
    sel = '0;
    valid = 1'b0;
    k = '0;
    // walk from the farthest offset down so the nearest request after last wins
    for (int i = NPORT; i >= 1; i--) begin
      k = 3'((int'(last) + i) % NPORT);
      if (req[k]) begin
        sel = k;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/switch_control.sv
// switch_control: round-robin header arbitration, XY routing and crossbar connection tracking for one router
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   sw           : slave side of switch_control_if (requests in; grants, free map, crossbar selects out)
//   address      : router address {X,Y}, X in the upper half of the flit
module switch_control
  import switch_control_pkg::*;
#(
  parameter logic [TAM_FLIT-1:0] address = '0
)
(
  input logic clock,
  input logic reset,
  switch_control_if.slave sw
);
  state_t state, nxt;
  logic [2:0] last, sel, dir, pick, route_dir;
  logic pick_valid;
  logic [NPORT-1:0] free, active, sender_d;
  logic [2:0] mux_in [NPORT];
  logic [2:0] mux_out [NPORT];
  logic [TAM_FLIT-1:0] head [NPORT];

  function automatic logic [2:0] xy(input logic [TAM_FLIT-1:0] t);
    logic [METADEFLIT-1:0] tx, ty, lx, ly;
    tx = t[TAM_FLIT-1:METADEFLIT];
    ty = t[METADEFLIT-1:0];
    lx = address[TAM_FLIT-1:METADEFLIT];
    ly = address[METADEFLIT-1:0];
    return tx > lx ? EAST : tx < lx ? WEST : ty > ly ? NORTH : ty < ly ? SOUTH : LOCAL;
  endfunction

  rr_picker u_pick (.req(sw.h), .last(last), .sel(pick), .valid(pick_valid));

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    assign head[i] = sw.data_in[i*TAM_FLIT +: TAM_FLIT];
    assign sw.mux_in[i*3 +: 3] = mux_in[i];
    assign sw.mux_out[i*3 +: 3] = mux_out[i];
  end

  assign sw.free = free;
  assign sw.ack_h = state == GRANT ? NPORT'(1) << sel : '0;
  assign route_dir = xy(head[sel]);

  // a request that vanished before ARB returns to IDLE rather than routing a stale sel
  always_comb begin
    nxt = state == IDLE ? (|sw.h ? ARB : IDLE) :
          state == ARB ? (pick_valid ? ROUTE : IDLE) :
          state == ROUTE ? ((sw.h[sel] && free[route_dir]) ? GRANT : IDLE) :
          IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last <= LOCAL;
      sel <= '0;
      dir <= '0;
      free <= '1;
      active <= '0;
      sender_d <= '0;
      mux_in <= '{default: '0};
      mux_out <= '{default: '0};
    end else begin
      state <= nxt;
      sender_d <= sw.sender;
      if (state == ARB && pick_valid) begin
        sel <= pick;
        last <= pick;
      end
      if (state == ROUTE) dir <= route_dir;
      if (state == GRANT) begin
        free[dir] <= 1'b0;
        mux_in[dir] <= sel;
        mux_out[sel] <= dir;
        active[sel] <= 1'b1;
      end
      // falling edge of sender ends the packet; a grant never targets an output being released
      for (int p = 0; p < NPORT; p++) begin
        if (active[p] && sender_d[p] && !sw.sender[p]) begin
          free[mux_out[p]] <= 1'b1;
          active[p] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_switch_control.sv
// tb_switch_control: scoreboard bench for switch_control at router address 8'h11
module tb_switch_control;
  import switch_control_pkg::*;
  localparam logic [7:0] ADDR = 8'h11;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  switch_control_if bus();
  switch_control #(.address(ADDR)) dut (.clock(clock), .reset(reset), .sw(bus));

  typedef struct {int in; int out;} grant_t;
  grant_t sbq[$];
  grant_t cur;
  bit pend = 0;
  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    failures++;
    $display("FAIL %s: no response within bound", name);
  endtask

  // XY rule as signed coordinate differences
  function automatic int ref_dir(int hd);
    int dx, dy;
    dx = (hd >> 4) - (int'(ADDR) >> 4);
    dy = (hd & 15) - (int'(ADDR) & 15);
    if (dx > 0) return 0;
    if (dx < 0) return 1;
    if (dy > 0) return 2;
    if (dy < 0) return 3;
    return 4;
  endfunction

  // monitor: pops an expectation on every grant pulse, checks crossbar state the next cycle
  always @(negedge clock) begin
    if (!reset) pend = 0;
    else begin
      if (pend) begin
        pend = 0;
        chk("free_after_grant", 32'(bus.free[cur.out]), 0);
        chk("mux_in", 32'(bus.mux_in[cur.out*3 +: 3]), cur.in);
        chk("mux_out", 32'(bus.mux_out[cur.in*3 +: 3]), cur.out);
      end
      if (bus.ack_h != 0) begin
        if (sbq.size() == 0) chk("unexpected_ack", 32'(bus.ack_h), 0);
        else begin
          cur = sbq.pop_front();
          chk("ack_input", 32'(bus.ack_h), 1 << cur.in);
          pend = 1;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_head(int p, logic [7:0] v);
    bus.data_in[p*8 +: 8] = v;
  endtask

  task automatic wait_ack(int p, output int c);
    c = 0;
    while (!bus.ack_h[p] && c < 40) begin
      tick(1);
      c++;
    end
    if (!bus.ack_h[p]) timeout_fail("ack_timeout");
  endtask

  task automatic grant_one(int p, logic [7:0] hd, bit lat);
    int c;
    set_head(p, hd);
    sbq.push_back('{p, ref_dir(int'(hd))});
    bus.h[p] = 1'b1;
    wait_ack(p, c);
    if (lat) chk("grant_latency", c, 3);
    bus.h[p] = 1'b0;
  endtask

  task automatic do_reset();
    bus.h = '0;
    bus.sender = '0;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p, o, c, hold;
    logic [7:0] hd;
    logic [7:0] dirheads [4];
    logic [7:0] rrheads [5];
    dirheads = '{8'h01, 8'h12, 8'h10, 8'h11};
    rrheads = '{8'h21, 8'h01, 8'h12, 8'h10, 8'h11};
    bus.h = '0;
    bus.sender = '0;
    bus.data_in = 40'($urandom) << 8 | 40'($urandom);
    tick(2);
    chk("reset_free", 32'(bus.free), 5'h1f);
    chk("reset_ack", 32'(bus.ack_h), 0);
    chk("reset_mux_in", 32'(bus.mux_in), 0);
    chk("reset_mux_out", 32'(bus.mux_out), 0);
    reset = 1'b1;
    tick(1);

    // basic grant: LOCAL head 8'h21 goes EAST
    grant_one(4, 8'h21, 1);
    tick(1);
    chk("basic_free_vec", 32'(bus.free), 5'b11110);
    bus.sender[4] = 1'b1;
    tick(2);
    bus.sender[4] = 1'b0;
    tick(1);
    chk("basic_release", 32'(bus.free), 5'h1f);

    // routing: directed heads first, then random ones
    for (int i = 0; i < 24; i++) begin
      p = $urandom_range(0, 4);
      hd = i < 4 ? dirheads[i] : 8'($urandom_range(0, 255));
      o = ref_dir(int'(hd));
      bus.data_in = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      tick(1);
      grant_one(p, hd, 1);
      tick(1);
      bus.sender[p] = 1'b1;
      hold = $urandom_range(1, 6);
      tick(hold);
      chk("busy_while_sending", 32'(bus.free[o]), 0);
      bus.sender[p] = 1'b0;
      tick(1);
      chk("free_after_release", 32'(bus.free[o]), 1);
    end

    // round-robin: all five request distinct outputs, order 0..4 twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < 5; q++) begin
        set_head(q, rrheads[q]);
        sbq.push_back('{q, q});
      end
      bus.h = 5'b11111;
      for (int k = 0; k < 5; k++) begin
        c = 0;
        while (bus.ack_h == 0 && c < 40) begin
          tick(1);
          c++;
        end
        if (bus.ack_h == 0) timeout_fail("rr_timeout");
        bus.sender = bus.sender | bus.ack_h;
        bus.h = bus.h & ~bus.ack_h;
        tick(1);
      end
      tick(2);
      chk("rr_all_busy", 32'(bus.free), 0);
      bus.sender[0] = 1'b0;
      tick(1);
      chk("partial_release", 32'(bus.free), 5'b00001);
      bus.sender = '0;
      tick(1);
      chk("rr_all_free", 32'(bus.free), 5'h1f);
    end

    // contention: inputs 0 and 4 both target WEST
    do_reset();
    set_head(0, 8'h01);
    set_head(4, 8'h01);
    sbq.push_back('{0, 1});
    bus.h = 5'b10001;
    wait_ack(0, c);
    bus.h[0] = 1'b0;
    tick(1);
    bus.sender[0] = 1'b1;
    tick(6);
    chk("contention_denied", 32'(bus.free[1]), 0);
    bus.sender[0] = 1'b0;
    c = 0;
    while (!bus.free[1] && c < 10) begin
      tick(1);
      c++;
    end
    chk("release_latency", c, 1);
    sbq.push_back('{4, 1});
    wait_ack(4, c);
    chk("contention_regrant_window", 32'(c <= 4), 1);
    bus.h[4] = 1'b0;
    tick(1);
    bus.sender[4] = 1'b1;
    tick(2);
    bus.sender[4] = 1'b0;
    tick(1);
    chk("contention_all_free", 32'(bus.free), 5'h1f);

    // async reset in ROUTE with two active connections
    do_reset();
    grant_one(0, 8'h21, 0);
    tick(1);
    bus.sender[0] = 1'b1;
    grant_one(1, 8'h12, 0);
    tick(1);
    bus.sender[1] = 1'b1;
    tick(1);
    chk("pre_reset_free", 32'(bus.free), 5'b11010);
    set_head(2, 8'h10);
    bus.h[2] = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("async_free", 32'(bus.free), 5'h1f);
    chk("async_ack", 32'(bus.ack_h), 0);
    chk("async_mux_in", 32'(bus.mux_in), 0);
    chk("async_mux_out", 32'(bus.mux_out), 0);
    bus.h = '0;
    bus.sender = '0;
    tick(1);
    reset = 1'b1;
    tick(8);
    chk("post_reset_idle_free", 32'(bus.free), 5'h1f);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
